// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI target-side port.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } spi_state_e;

    localparam int         SPI_DW      = 8;
    localparam int         SPI_SYNC    = 2;
    localparam logic [7:0] SPI_TX_FILL = 8'hFF;

    // Shift one bit into a byte from the end selected by the bit order.
    function automatic logic [7:0] spi_shift(input logic [7:0] v, input logic lsb, input logic din);
        return lsb ? {din, v[7:1]} : {v[6:0], din};
    endfunction

    // Bit that goes on the wire first for the selected bit order.
    function automatic logic spi_txbit(input logic [7:0] v, input logic lsb);
        return lsb ? v[0] : v[7];
    endfunction

endpackage

// File: rtl/spi_slave_rxq.sv
// spi_slave_rxq: receive queue for the SPI target port.
// SPI_SLAVE_RXFIFO_EN defined: 4-entry FIFO; otherwise a single holding register.
module spi_slave_rxq
    import spi_pkg::*;
(
    input  logic        pclk,
    input  logic        presetn,
    input  logic        push,
    input  logic [7:0]  push_data,
    input  logic        rx_ready,
    input  logic        ovr_clr,
    output logic [7:0]  rx_data,
    output logic        empty,
    output logic        overrun
);

    logic pop;
    logic full;
    logic ovf;
    logic wr;

    // A pop in the same cycle frees the slot, so a full queue only drops when nothing leaves.
    assign pop = rx_ready & ~empty;
    assign ovf = push & full & ~pop;
    assign wr  = push & ~ovf;

`ifdef SPI_SLAVE_RXFIFO_EN
    logic [7:0] mem [4];
    logic [1:0] wp, rp;
    logic [2:0] cnt;

    assign full    = (cnt == 3'd4);
    assign empty   = (cnt == 3'd0);
    assign rx_data = mem[rp];

    // Circular buffer; pointers wrap naturally at 2 bits.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < 4; i++) mem[i] <= '0;
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr) begin
                mem[wp] <= push_data;
                wp      <= wp + 2'd1;
            end
            if (pop) rp <= rp + 2'd1;
            cnt <= cnt + {2'b00, wr} - {2'b00, pop};
        end
    end
`else
    logic [7:0] hold;
    logic       vld;

    assign full    = vld;
    assign empty   = ~vld;
    assign rx_data = hold;

    // Single holding register; a push with a simultaneous pop replaces the entry.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            hold <= '0;
            vld  <= 1'b0;
        end else if (wr) begin
            hold <= push_data;
            vld  <= 1'b1;
        end else if (pop) begin
            vld  <= 1'b0;
        end
    end
`endif

    // Sticky drop flag; a drop in the clearing cycle wins.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)     overrun <= 1'b0;
        else if (ovf)     overrun <= 1'b1;
        else if (ovr_clr) overrun <= 1'b0;
    end

endmodule

// File: rtl/spi_slave_port.sv
// spi_slave_port: SPI target port oversampling sclk/ss/mosi in the pclk domain.
// Optional build macro SPI_SLAVE_RXFIFO_EN selects a 4-entry rx FIFO.
module spi_slave_port
    import spi_pkg::*;
(
    input  logic       pclk,
    input  logic       presetn,
    input  logic       sclk_in,
    input  logic       ss_in,
    input  logic       mosi_in,
    output logic       miso_out,
    output logic       miso_oe,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       lsbfe,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       overrun,
    input  logic       ovr_clr,
    output logic       byte_done
);

    logic [SPI_SYNC-1:0] sclk_sync, ss_sync, mosi_sync;
    logic       sclk_s, ss_s, mosi_s, sclk_d;
    logic       rise, fall, lead, trail;
    spi_state_e state, state_nxt;
    logic       load_now, in_shift;
    logic       samp_ev, shft_ev, shift_go, last_samp, reload_now;
    logic [7:0] tx_buf, tx_sr, rx_sr, tx_src;
    logic       tx_full, shift_q, reload_pend, done_q;
    logic [2:0] bit_cnt;
    logic       rxq_empty;

    assign sclk_s = sclk_sync[SPI_SYNC-1];
    assign ss_s   = ss_sync[SPI_SYNC-1];
    assign mosi_s = mosi_sync[SPI_SYNC-1];

    // Two-flop synchronizers plus one extra sclk stage for edge detection.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SPI_SYNC-2:0], sclk_in};
            ss_sync   <= {ss_sync[SPI_SYNC-2:0], ss_in};
            mosi_sync <= {mosi_sync[SPI_SYNC-2:0], mosi_in};
            sclk_d    <= sclk_s;
        end
    end

    assign rise  = sclk_s & ~sclk_d;
    assign fall  = ~sclk_s & sclk_d;
    assign lead  = cpol ? fall : rise;
    assign trail = cpol ? rise : fall;

    // FSM state register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) state <= IDLE;
        else          state <= state_nxt;
    end

    // FSM next state; ss release from any state returns to IDLE.
    always_comb begin
        state_nxt = state;
        load_now  = 1'b0;
        in_shift  = 1'b0;
        miso_oe   = 1'b0;
        case (state)
            IDLE:  if (!ss_s) state_nxt = LOAD;
            LOAD: begin
                miso_oe   = 1'b1;
                load_now  = ~ss_s;
                state_nxt = ss_s ? IDLE : SHIFT;
            end
            SHIFT: begin
                miso_oe  = 1'b1;
                in_shift = ~ss_s;
                if (ss_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign samp_ev   = in_shift & (cpha ? trail : lead);
    assign shft_ev   = in_shift & (cpha ? lead : trail);
    assign shift_go  = in_shift & shift_q;
    assign last_samp = samp_ev & (bit_cnt == 3'd7);
    assign tx_src    = tx_full ? tx_buf : SPI_TX_FILL;
    // Any cycle that moves the tx buffer into the shift path empties the buffer.
    assign reload_now = load_now | (last_samp & ~cpha) | (shift_go & reload_pend);
    assign tx_ready   = ~tx_full;

    // Tx buffer and shift path; shift edges act one cycle after detection.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            tx_sr       <= SPI_TX_FILL;
            miso_out    <= 1'b1;
            shift_q     <= 1'b0;
            reload_pend <= 1'b0;
        end else begin
            shift_q <= shft_ev;
            if (reload_now) tx_full <= 1'b0;
            if (tx_load && !tx_full) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end
            if (!in_shift) reload_pend <= 1'b0;
            if (state == IDLE) begin
                miso_out <= 1'b1;
            end else if (load_now) begin
                if (cpha) begin
                    tx_sr <= tx_src;
                end else begin
                    tx_sr    <= spi_shift(tx_src, lsbfe, 1'b1);
                    miso_out <= spi_txbit(tx_src, lsbfe);
                end
            end else if (shift_go) begin
                if (reload_pend) begin
                    tx_sr       <= spi_shift(tx_src, lsbfe, 1'b1);
                    miso_out    <= spi_txbit(tx_src, lsbfe);
                    reload_pend <= 1'b0;
                end else begin
                    tx_sr    <= spi_shift(tx_sr, lsbfe, 1'b1);
                    miso_out <= spi_txbit(tx_sr, lsbfe);
                end
            end else if (last_samp) begin
                // cpha=1 waits for the next shift edge; cpha=0 reloads now.
                if (cpha) reload_pend <= 1'b1;
                else      tx_sr       <= tx_src;
            end
        end
    end

    // Rx assembly; leaving SHIFT discards any partial byte.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rx_sr     <= '0;
            bit_cnt   <= '0;
            done_q    <= 1'b0;
            byte_done <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            byte_done <= done_q;
            if (!in_shift) begin
                bit_cnt <= '0;
            end else if (samp_ev) begin
                rx_sr   <= spi_shift(rx_sr, lsbfe, mosi_s);
                bit_cnt <= bit_cnt + 3'd1;
                done_q  <= (bit_cnt == 3'd7);
            end
        end
    end

    spi_slave_rxq u_rxq (
        .pclk      (pclk),
        .presetn   (presetn),
        .push      (done_q),
        .push_data (rx_sr),
        .rx_ready  (rx_ready),
        .ovr_clr   (ovr_clr),
        .rx_data   (rx_data),
        .empty     (rxq_empty),
        .overrun   (overrun)
    );

    assign rx_valid = ~rxq_empty;

endmodule

// File: tb/tb_spi_slave_port.sv
// tb_spi_slave_port: directed bench with a cycle-level queue model of the target port.
module tb_spi_slave_port;

    logic pclk = 1'b0, presetn = 1'b0;
    logic sclk_in = 1'b0, ss_in = 1'b1, mosi_in = 1'b0;
    logic cpol = 1'b0, cpha = 1'b0, lsbfe = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic tx_load = 1'b0, rx_ready = 1'b0, ovr_clr = 1'b0;
    logic miso_out, miso_oe, tx_ready, rx_valid, overrun, byte_done;
    logic [7:0] rx_data;

`ifdef SPI_SLAVE_RXFIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    localparam int H = 6;   // sclk half period in pclk cycles

    int n_chk = 0, n_fail = 0;
    int cyc = 0, push_cyc = -1, oe_on = -1, oe_off = -1;
    logic [7:0] push_byte = 8'h00;
    bit clr_at_push = 0, pop_at_push = 0;
    logic [7:0] mq[$];
    bit m_ovr = 0, m_bd = 0;

    spi_slave_port dut (
        .pclk(pclk), .presetn(presetn), .sclk_in(sclk_in), .ss_in(ss_in), .mosi_in(mosi_in),
        .miso_out(miso_out), .miso_oe(miso_oe), .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe),
        .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .overrun(overrun), .ovr_clr(ovr_clr),
        .byte_done(byte_done)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: a byte lands 4 cycles after its 8th sample edge; pops act on rx_ready with data present.
    always @(posedge pclk) begin
        bit pop, push, ovf, oe;
        cyc++;
        if (!presetn) begin
            mq.delete();
            m_ovr = 0; m_bd = 0;
            push_cyc = -1; oe_on = -1; oe_off = -1;
        end else begin
            pop  = (mq.size() > 0) && rx_ready;
            push = (cyc == push_cyc);
            ovf  = 0;
            m_bd = push;
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(push_byte);
                else ovf = 1;
            end
            if (ovf) m_ovr = 1;
            else if (ovr_clr) m_ovr = 0;
        end
        oe = (cyc >= oe_on) && !(oe_off >= oe_on && cyc >= oe_off);
        #3;
        chk("rx_valid", rx_valid, mq.size() > 0);
        if (mq.size() > 0) chk("rx_data", rx_data, mq[0]);
        chk("overrun", overrun, m_ovr);
        chk("byte_done", byte_done, m_bd);
        chk("miso_oe", miso_oe, oe);
    end

    task automatic tick();
        @(negedge pclk);
        if (clr_at_push) ovr_clr  = (cyc + 1 == push_cyc);
        if (pop_at_push) rx_ready = (cyc + 1 == push_cyc);
    endtask

    function automatic int bi(input int i);
        return lsbfe ? i : 7 - i;
    endfunction

    // Master side of one select window, nbits clock pulses.
    task automatic xfer(input logic [7:0] mo, input int nbits, input bit release_ss, output logic [7:0] mi);
        mi = 8'h00;
        sclk_in = cpol;
        repeat (4) tick();
        ss_in = 1'b0;
        oe_on = cyc + 3;
        if (!cpha) mosi_in = mo[bi(0)];
        repeat (8) tick();
        for (int i = 0; i < nbits; i++) begin
            sclk_in = ~cpol;
            if (!cpha) mi[bi(i)] = miso_out;
            else       mosi_in   = mo[bi(i)];
            if (i == 7 && !cpha) begin push_cyc = cyc + 4; push_byte = mo; end
            repeat (H) tick();
            sclk_in = cpol;
            if (cpha)       mi[bi(i)] = miso_out;
            else if (i < 7) mosi_in   = mo[bi(i + 1)];
            if (i == 7 && cpha) begin push_cyc = cyc + 4; push_byte = mo; end
            repeat (H) tick();
        end
        if (release_ss) begin
            ss_in  = 1'b1;
            oe_off = cyc + 3;
            repeat (8) tick();
        end
    endtask

    task automatic load(input logic [7:0] v);
        tx_data = v; tx_load = 1'b1; tick(); tx_load = 1'b0; tick();
    endtask

    task automatic pop_one();
        rx_ready = 1'b1; tick(); rx_ready = 1'b0; tick();
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_miso_out"}, miso_out, 1'b1);
        chk({nm, "_miso_oe"}, miso_oe, 1'b0);
        chk({nm, "_tx_ready"}, tx_ready, 1'b1);
        chk({nm, "_rx_valid"}, rx_valid, 1'b0);
        chk({nm, "_rx_data"}, rx_data, 8'h00);
        chk({nm, "_overrun"}, overrun, 1'b0);
        chk({nm, "_byte_done"}, byte_done, 1'b0);
    endtask

    initial begin
        logic [7:0] mi;
        logic [7:0] txv [4];
        logic [7:0] expq[$];
        txv[0] = 8'h00; txv[1] = 8'h4B; txv[2] = 8'hD2; txv[3] = 8'h1E;

        repeat (3) tick();
        check_reset("reset");
        presetn = 1'b1;
        repeat (4) tick();

        // Mode 0 MSB first; second load while full must be ignored.
        cpol = 0; cpha = 0; lsbfe = 0;
        load(8'h3C);
        chk("tx_ready_loaded", tx_ready, 1'b0);
        load(8'h99);
        xfer(8'hA5, 8, 1, mi);
        chk("m0_master_rx", mi, 8'h3C);
        chk("m0_rx_data", rx_data, 8'hA5);
        chk("m0_rx_valid", rx_valid, 1'b1);
        chk("m0_tx_ready", tx_ready, 1'b1);
        pop_one();

        // Modes 1..3, LSB first.
        lsbfe = 1;
        for (int m = 1; m < 4; m++) begin
            cpol = m[1]; cpha = m[0];
            load(txv[m]);
            xfer(8'h81, 8, 1, mi);
            chk($sformatf("mode%0d_master_rx", m), mi, txv[m]);
            chk($sformatf("mode%0d_rx_data", m), rx_data, 8'h81);
            pop_one();
        end

        // Empty buffer sends filler; aborted partial byte leaves nothing behind.
        cpol = 0; cpha = 0; lsbfe = 0;
        repeat (8) tick();
        xfer(8'h00, 8, 1, mi);
        chk("empty_tx_master_rx", mi, 8'hFF);
        pop_one();
        xfer(8'h77, 5, 1, mi);
        chk("partial_no_valid", rx_valid, 1'b0);
        xfer(8'hC3, 8, 1, mi);
        chk("after_partial_rx", rx_data, 8'hC3);
        pop_one();

        // Overflow with no pops.
        for (int b = 1; b <= DEPTH + 1; b++) xfer(8'(b), 8, 1, mi);
        chk("ovf_overrun", overrun, 1'b1);
        chk("ovf_head", rx_data, 8'h01);
        for (int k = 1; k <= DEPTH; k++) begin
            chk($sformatf("ovf_pop%0d", k), rx_data, 8'(k));
            pop_one();
        end
        chk("ovf_drained", rx_valid, 1'b0);
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0; tick();
        chk("ovr_clr", overrun, 1'b0);

        // Clear coinciding with an overflow keeps the flag.
        for (int b = 0; b < DEPTH; b++) xfer(8'h10 + 8'(b), 8, 1, mi);
        clr_at_push = 1;
        xfer(8'hEE, 8, 1, mi);
        clr_at_push = 0; ovr_clr = 1'b0;
        chk("clr_vs_ovf", overrun, 1'b1);
        for (int k = 0; k < DEPTH; k++) pop_one();
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0; tick();

        // Push and pop together on a full queue: no drop.
        for (int b = 1; b <= DEPTH; b++) xfer(8'h20 + 8'(b), 8, 1, mi);
        pop_at_push = 1;
        xfer(8'h2F, 8, 1, mi);
        pop_at_push = 0; rx_ready = 1'b0;
        chk("pushpop_no_ovr", overrun, 1'b0);
        for (int b = 2; b <= DEPTH; b++) expq.push_back(8'h20 + 8'(b));
        expq.push_back(8'h2F);
        foreach (expq[k]) begin
            chk($sformatf("pushpop_pop%0d", k), rx_data, expq[k]);
            pop_one();
        end

        // Reset in the middle of a byte.
        xfer(8'hFF, 5, 0, mi);
        load(8'h55);
        presetn = 1'b0;
        tick(); tick();
        check_reset("midbyte_reset");
        ss_in = 1'b1; sclk_in = 1'b0;
        repeat (3) tick();
        presetn = 1'b1;
        repeat (4) tick();
        load(8'h3C);
        xfer(8'h5A, 8, 1, mi);
        chk("post_reset_rx", rx_data, 8'h5A);
        chk("post_reset_master_rx", mi, 8'h3C);
        pop_one();

        repeat (4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
